// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU operand-issue stage and the ALU units it
//   feeds.
//   - ALU_OP_W      : default opcode width
//   - OP_*          : opcode values presented on in_op / out_op
//   - stage_state_t : occupancy state of the operand-stage skid buffer
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] OP_AND = 4'd0;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 4'd1;
  localparam logic [ALU_OP_W-1:0] OP_XOR = 4'd2;
  localparam logic [ALU_OP_W-1:0] OP_ADD = 4'd3;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 4'd4;

  // EMPTY: no live entry; ONE: main slot live; FULL: main and skid slots live
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

endpackage

// File: rtl/alu_operand_stage_if.sv
// -----------------------------------------------------------------------------
// alu_operand_stage_if
//   Bundles the decode-side and ALU-side signals of the operand-issue stage.
//
//   Handshake rule (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both 1. A producer holding valid=1 keeps its payload
//   stable until the transfer; ready never depends combinationally on valid
//   of the same side.
//
//   Signals
//     in_valid/in_ready, in_op, in_a, in_b  : decode -> stage
//     out_valid/out_ready, input1, input2,
//     out_op                                 : stage -> ALU
//     issue_cnt                              : count of ALU-side transfers
//   Modports
//     master : environment side (decode + ALU/writeback)
//     slave  : the operand stage itself
// -----------------------------------------------------------------------------
interface alu_operand_stage_if #(
  parameter int width = 32,
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
);

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [width-1:0]  in_a;
  logic [width-1:0]  in_b;

  logic              out_valid;
  logic              out_ready;
  logic [width-1:0]  input1;
  logic [width-1:0]  input2;
  logic [OP_W-1:0]   out_op;

  logic [CNT_W-1:0]  issue_cnt;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, input1, input2, out_op, issue_cnt
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, input1, input2, out_op, issue_cnt
  );

endinterface

// File: rtl/alu_operand_slot.sv
// -----------------------------------------------------------------------------
// alu_operand_slot
//   One {op, a, b} holding register with load enable and asynchronous
//   active-high reset to zero. Used as both the main and the skid slot of the
//   operand stage.
//
//   Ports
//     clk, rst          : clock, async active-high reset
//     load              : capture d_* on the next rising edge
//     d_op, d_a, d_b    : data to capture
//     q_op, q_a, q_b    : held data
// -----------------------------------------------------------------------------
module alu_operand_slot #(
  parameter int width = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [OP_W-1:0]  d_op,
  input  logic [width-1:0] d_a,
  input  logic [width-1:0] d_b,
  output logic [OP_W-1:0]  q_op,
  output logic [width-1:0] q_a,
  output logic [width-1:0] q_b
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_op <= '0;
      q_a  <= '0;
      q_b  <= '0;
    end else if (load) begin
      q_op <= d_op;
      q_a  <= d_a;
      q_b  <= d_b;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//   Operand-issue stage in front of the ALU units. Accepts {opcode, A, B} from
//   decode, holds up to two operations in a main + skid slot pair, and drives
//   input1/input2/out_op to the ALU in strict FIFO order. A synchronous flush
//   discards everything buffered; issue_cnt counts ALU-side transfers and is
//   only cleared by reset.
//
//   Ports
//     clk        : rising-edge clock
//     rst        : asynchronous, active-high reset
//     flush      : synchronous discard of all buffered entries
//     bus        : handshake/data bundle (slave modport)
//     fsm_state  : current occupancy state, for observation
//
//   in_ready and out_valid are decoded from the state register alone, so there
//   is no combinational path from out_ready to in_ready, and an asynchronous
//   reset drops out_valid / raises in_ready without waiting for a clock edge.
// -----------------------------------------------------------------------------
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int width = 32,
  parameter int OP_W  = ALU_OP_W,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  alu_operand_stage_if.slave   bus,
  output stage_state_t         fsm_state
);

  stage_state_t state_q;
  stage_state_t state_d;

  logic accept;
  logic issue;
  logic stage_in_ready;
  logic stage_out_valid;

  // slot control, produced by the output process
  logic main_load;
  logic skid_load;
  logic main_from_skid;

  logic [OP_W-1:0]  main_d_op;
  logic [width-1:0] main_d_a;
  logic [width-1:0] main_d_b;

  logic [OP_W-1:0]  main_op;
  logic [width-1:0] main_a;
  logic [width-1:0] main_b;
  logic [OP_W-1:0]  skid_op;
  logic [width-1:0] skid_a;
  logic [width-1:0] skid_b;

  logic [CNT_W-1:0] issue_cnt_q;

  // ready/valid come straight from the state register
  assign stage_in_ready  = (state_q != FULL);
  assign stage_out_valid = (state_q != EMPTY);

  assign accept = bus.in_valid & stage_in_ready;
  assign issue  = stage_out_valid & bus.out_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic; flush wins over any same-cycle accept
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) state_d = ONE;
        ONE: begin
          if (accept && !issue) begin
            state_d = FULL;
          end else if (!accept && issue) begin
            state_d = EMPTY;
          end
        end
        FULL:  if (issue) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: slot load enables. Slots load only on an accept or on the
  // skid->main move; on flush nothing loads since the contents are discarded.
  // ---------------------------------------------------------------------------
  always_comb begin
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (!flush) begin
      unique case (state_q)
        EMPTY: main_load = accept;
        ONE: begin
          // head leaves this cycle: the new entry replaces it directly
          main_load = accept & issue;
          // head stays: the new entry queues behind it
          skid_load = accept & ~issue;
        end
        FULL: begin
          main_load      = issue;
          main_from_skid = issue;
        end
        default: begin
          main_load      = 1'b0;
          skid_load      = 1'b0;
          main_from_skid = 1'b0;
        end
      endcase
    end
  end

  // main slot takes either fresh decode data or the queued skid entry
  always_comb begin
    main_d_op = bus.in_op;
    main_d_a  = bus.in_a;
    main_d_b  = bus.in_b;
    if (main_from_skid) begin
      main_d_op = skid_op;
      main_d_a  = skid_a;
      main_d_b  = skid_b;
    end
  end

  alu_operand_slot #(
    .width (width),
    .OP_W  (OP_W)
  ) u_main_slot (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .d_op (main_d_op),
    .d_a  (main_d_a),
    .d_b  (main_d_b),
    .q_op (main_op),
    .q_a  (main_a),
    .q_b  (main_b)
  );

  alu_operand_slot #(
    .width (width),
    .OP_W  (OP_W)
  ) u_skid_slot (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .d_op (bus.in_op),
    .d_a  (bus.in_a),
    .d_b  (bus.in_b),
    .q_op (skid_op),
    .q_a  (skid_a),
    .q_b  (skid_b)
  );

  // ---------------------------------------------------------------------------
  // Issue counter: counts every ALU-side transfer, including one that lands in
  // the same cycle as a flush; wraps naturally.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q <= '0;
    end else if (issue) begin
      issue_cnt_q <= issue_cnt_q + 1'b1;
    end
  end

  assign bus.in_ready  = stage_in_ready;
  assign bus.out_valid = stage_out_valid;
  assign bus.input1    = main_a;
  assign bus.input2    = main_b;
  assign bus.out_op    = main_op;
  assign bus.issue_cnt = issue_cnt_q;
  assign fsm_state     = state_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
//   Self-checking bench for alu_operand_stage. The reference is a bounded
//   queue of {op, a, b} entries (capacity 2) plus an issue counter.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;
  import alu_pkg::*;

  localparam int W     = 32;
  localparam int OW    = 4;
  localparam int CW    = 16;
  localparam int EW    = OW + 2 * W;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst;
  logic flush;
  stage_state_t fsm_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_operand_stage_if #(.width(W), .OP_W(OW), .CNT_W(CW)) bus ();

  alu_operand_stage #(
    .width (W),
    .OP_W  (OW),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  logic [CW-1:0] exp_cnt;
  int            n_checks;
  int            n_errs;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply one cycle of stimulus (called at posedge+1), compare at the
  // falling edge, then advance the model across the rising edge.
  // ---------------------------------------------------------------------------
  task automatic cycle(input logic v, input logic [OW-1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ordy, input logic fl, input bit chk);
    logic          acc;
    logic          iss;
    logic [EW-1:0] head;
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = ordy;
    flush         = fl;
    @(negedge clk);
    if (chk) begin
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_q.size() < 2});
      check("issue_cnt", {16'd0, bus.issue_cnt}, {16'd0, exp_cnt});
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        check("out_op", {28'd0, bus.out_op}, {28'd0, head[EW-1 -: OW]});
        check("input1", bus.input1, head[2*W-1 -: W]);
        check("input2", bus.input2, head[W-1:0]);
      end
    end
    acc = v && (exp_q.size() < 2);
    iss = ordy && (exp_q.size() != 0);
    @(posedge clk);
    if (iss) exp_cnt++;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (iss) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({op, a, b});
    end
    #1;
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, ordy, 1'b0, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [OW-1:0] rop;
    logic [CW-1:0] base_cnt;
    n_checks = 0;
    n_errs   = 0;
    exp_cnt  = '0;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_input1", bus.input1, 32'd0);
    check("rst_input2", bus.input2, 32'd0);
    check("rst_out_op", {28'd0, bus.out_op}, 32'd0);
    check("rst_issue_cnt", {16'd0, bus.issue_cnt}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: single XOR, one-cycle latency
    cycle(1'b1, OP_XOR, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 1'b0, 1'b1);
    check("t1_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t1_xor", bus.input1 ^ bus.input2, 32'hFFFFFFFF);
    idle(1'b1, 2);

    // 2: three back-to-back ops with the ALU stalled, then drain
    base_cnt = exp_cnt;
    cycle(1'b1, OP_ADD, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, OP_SUB, 32'h00000003, 32'h00000004, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, OP_AND, 32'h00000005, 32'h00000006, 1'b0, 1'b0, 1'b1);
    check("t2_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
    cycle(1'b1, OP_AND, 32'h00000005, 32'h00000006, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, OP_AND, 32'h00000005, 32'h00000006, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 3);
    check("t2_issued", {16'd0, bus.issue_cnt - base_cnt}, 32'd3);

    // 3: FULL and stalled for 5 cycles, outputs held
    cycle(1'b1, OP_ADD, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, OP_OR, 32'h0F0F0F0F, 32'h33333333, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, OP_SUB, 32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 1'b1);
      check("t3_hold_input1", bus.input1, 32'h11111111);
      check("t3_hold_op", {28'd0, bus.out_op}, {28'd0, OP_ADD});
    end
    idle(1'b1, 3);

    // 4: flush together with an accept while in ONE
    cycle(1'b1, OP_AND, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, OP_OR, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1);
    check("t4_valid_after_flush", {31'd0, bus.out_valid}, 32'd0);
    check("t4_ready_after_flush", {31'd0, bus.in_ready}, 32'd1);
    cycle(1'b1, OP_XOR, 32'hCAFEF00D, 32'h0BADF00D, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 2);

    // flush while issuing: the issue still counts
    cycle(1'b1, OP_ADD, 32'h0000000A, 32'h0000000B, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, OP_SUB, 32'h0000000C, 32'h0000000D, 1'b1, 1'b1, 1'b1);
    idle(1'b1, 2);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rop = OW'($urandom_range(0, 4));
      cycle(1'($urandom_range(0, 3) != 0), rop, $urandom, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0), 1'b1);
    end
    idle(1'b1, 3);

    // 6: asynchronous reset while FULL
    cycle(1'b1, OP_ADD, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, OP_OR, 32'h0F0F0F0F, 32'h33333333, 1'b0, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t6_async_ready", {31'd0, bus.in_ready}, 32'd1);
    check("t6_async_cnt", {16'd0, bus.issue_cnt}, 32'd0);
    exp_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(1'b1, 2);

    // 5: counter wrap at 0xFFFF
    for (int i = 0; i < 70000 && exp_cnt != 16'hFFFF; i++) begin
      cycle(1'b1, OP_XOR, $urandom, $urandom, 1'b1, 1'b0, (i % 4096) == 0);
    end
    check("t5_at_ffff", {16'd0, bus.issue_cnt}, 32'h0000FFFF);
    cycle(1'b1, OP_AND, 32'h1, 32'h2, 1'b1, 1'b0, 1'b1);
    check("t5_wrap", {16'd0, bus.issue_cnt}, 32'd0);
    idle(1'b1, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
